// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built on one shared 4-bit slice, one nibble per clock,
// least-significant nibble first, with the inter-nibble carry held in a register.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 sum_valid,
   input  logic                 sum_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic                 busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t        state;
   state_t        next;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          carry_r;
   logic [IW-1:0] idx;

   logic [3:0] low;
   logic       c3;
   logic       co;
   logic [3:0] nib;

   // Low three bits via a narrow add; bit 3 is built explicitly so its
   // carry-in is visible for the signed-overflow flag.
   assign low = {1'b0, op_a[2:0]} + {1'b0, op_b[2:0]} + {3'b000, carry_r};
   assign c3  = low[3];
   assign nib = {op_a[3] ^ op_b[3] ^ c3, low[2:0]};
   assign co  = (op_a[3] & op_b[3]) | (c3 & (op_a[3] ^ op_b[3]));

   assign start_ready = (state == IDLE);
   assign sum_valid   = (state == DONE);
   assign busy        = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE: if (start_valid) next = ADD;
         ADD:  if (idx == LAST) next = DONE;
         DONE: if (sum_ready)   next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_a    <= '0;
         op_b    <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_valid) begin
                  op_a    <= a;
                  op_b    <= b;
                  carry_r <= cin;
                  idx     <= '0;
                  sum     <= '0;
               end
            end
            ADD: begin
               for (int k = 0; k < NIBBLES; k++)
                  if (idx == IW'(k)) sum[4*k +: 4] <= nib;
               carry_r <= co;
               op_a    <= op_a >> 4;
               op_b    <= op_b >> 4;
               idx     <= idx + IW'(1);
               if (idx == LAST) begin
                  cout <= co;
                  ovf  <= c3 ^ co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4) with a result
// scoreboard fed at accept time and drained when sum_valid is seen.
module tb_nibble_serial_add_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sum_valid;
   logic        sum_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clock(clock),
      .reset(reset),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .a(a),
      .b(b),
      .cin(cin),
      .sum_valid(sum_valid),
      .sum_ready(sum_ready),
      .sum(sum),
      .cout(cout),
      .ovf(ovf),
      .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic c);
      exp_t       e;
      logic [16:0] full;
      logic        c15;
      full = {1'b0, x} + {1'b0, y} + {16'd0, c};
      c15  = full[15] ^ x[15] ^ y[15];
      e.s  = full[15:0];
      e.co = full[16];
      e.ov = c15 ^ full[16];
      return e;
   endfunction

   task automatic issue(input logic [15:0] x, input logic [15:0] y,
                        input logic c);
      int n;
      start_valid = 1'b1;
      a   = x;
      b   = y;
      cin = c;
      n = 0;
      while (!start_ready && n < 50) begin
         tick();
         n++;
      end
      check("accept_wait", {31'd0, n < 50}, 32'd1);
      q.push_back(model(x, y, c));
      tick();
      acc_cyc     = cyc;
      start_valid = 1'b0;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
   endtask

   task automatic collect(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (!sum_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, cyc - acc_cyc, 32'd4);
      if (q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         check({tag, "_sum"}, {16'd0, sum}, {16'd0, e.s});
         check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.co});
         check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ov});
      end
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   initial begin
      logic [15:0] held;
      int          prev;
      reset       = 1'b1;
      start_valid = 1'b0;
      a           = 16'h0;
      b           = 16'h0;
      cin         = 1'b0;
      sum_ready   = 1'b0;
      tick();
      tick();
      check("rst_start_ready", {31'd0, start_ready}, 32'd1);
      check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      reset     = 1'b0;
      sum_ready = 1'b1;
      tick();

      issue(16'h1234, 16'h4321, 1'b0);
      collect("basic");
      issue(16'hFFFF, 16'h0001, 1'b0);
      collect("ripple1");
      issue(16'h0FFF, 16'h0000, 1'b1);
      collect("ripple2");
      issue(16'h7FFF, 16'h0001, 1'b0);
      collect("ovf_pos");
      issue(16'h8000, 16'h8000, 1'b0);
      collect("ovf_neg");
      tick();
      check("handoff_ready", {31'd0, start_ready}, 32'd1);

      sum_ready = 1'b0;
      issue(16'h1111, 16'h2222, 1'b0);
      collect("bp_first");
      start_valid = 1'b1;
      a    = 16'h0F0F;
      b    = 16'h0101;
      cin  = 1'b1;
      held = sum;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid", {31'd0, sum_valid}, 32'd1);
         check("bp_sum_hold", {16'd0, sum}, {16'd0, held});
         check("bp_start_ready", {31'd0, start_ready}, 32'd0);
         check("bp_flags_hold", {30'd0, cout, ovf}, 32'd0);
      end
      sum_ready = 1'b1;
      tick();
      check("bp_after_ready", {31'd0, start_ready}, 32'd1);
      check("bp_after_valid", {31'd0, sum_valid}, 32'd0);
      check("bp_idle_sum", {16'd0, sum}, {16'd0, held});
      q.push_back(model(16'h0F0F, 16'h0101, 1'b1));
      tick();
      acc_cyc     = cyc;
      start_valid = 1'b0;
      check("bp_pending_busy", {31'd0, busy}, 32'd1);
      collect("bp_pending");

      issue(16'h1234, 16'h1111, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(q.pop_front());
      check("mid_rst_ready", {31'd0, start_ready}, 32'd1);
      check("mid_rst_valid", {31'd0, sum_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_sum", {16'd0, sum}, 32'd0);
      check("mid_rst_cout", {31'd0, cout}, 32'd0);
      issue(16'h0001, 16'h0001, 1'b0);
      collect("post_rst");

      prev = 0;
      for (int i = 0; i < 8; i++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         if (i > 0) check("b2b_spacing", acc_cyc - prev, 32'd6);
         prev = acc_cyc;
         collect("b2b");
      end
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
